// File: rtl/key_sw_pkg.sv
// key_sw_pkg: register map and default debounce length for the key/switch input port.
package key_sw_pkg;
  localparam logic [1:0] ADDR_SW     = 2'd0;
  localparam logic [1:0] ADDR_KEYLVL = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;
  localparam logic [1:0] ADDR_MASK   = 2'd3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchroniser and hold-time debouncer for one active-low key, with a press pulse.
module debounce_bit #(
  parameter int CYCLES = 4,
  parameter int CNT_W  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic fall
);
  logic [1:0] sync_q;
  logic [CNT_W-1:0] cnt;
  logic sync;
  logic done;
  assign sync = sync_q[1];
  assign done = (sync != stable) && (cnt == CNT_W'(CYCLES - 1));
  // a 1->0 transition of the accepted level is a press
  assign fall = done && stable;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], pin};
      cnt    <= (sync == stable || done) ? '0 : cnt + 1'b1;
      if (done) stable <= sync;
    end
endmodule

// File: rtl/key_sw_input_port.sv
// key_sw_input_port: memory-mapped reader for DE2 slide switches and debounced pushbuttons,
// with read-to-clear press latches and a masked level interrupt.
module key_sw_input_port
  import key_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);
  logic [17:0] sw_q1, sw_q2;
  logic [3:0]  stable_key, fall, pending, mask, pend_next, mask_next, rd_clr;
  logic [31:0] rd_mux;
  logic        unused_wr;
  assign unused_wr = ^wr_data[31:4];
  for (genvar i = 0; i < 4; i++) begin : g_key
    debounce_bit #(.CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(CLOCK_50), .rst(reset), .pin(KEY[i]), .stable(stable_key[i]), .fall(fall[i])
    );
  end
  // only bits that were actually returned get cleared; a concurrent press still lands
  always_comb begin
    rd_clr    = (rd_en && addr == ADDR_PEND) ? pending : 4'h0;
    pend_next = (pending & ~rd_clr) | fall;
    mask_next = (wr_en && addr == ADDR_MASK) ? wr_data[3:0] : mask;
    rd_mux    = addr == ADDR_SW     ? {14'b0, sw_q2} :
                addr == ADDR_KEYLVL ? {28'b0, ~stable_key} :
                addr == ADDR_PEND   ? {28'b0, pending} : {28'b0, mask};
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      sw_q1   <= '0;
      sw_q2   <= '0;
      pending <= '0;
      mask    <= '0;
      rd_data <= '0;
      irq     <= 1'b0;
    end else begin
      sw_q1   <= SW;
      sw_q2   <= sw_q1;
      pending <= pend_next;
      mask    <= mask_next;
      irq     <= |(pend_next & mask_next);
      if (rd_en) rd_data <= rd_mux;
    end
endmodule

// File: tb/tb_key_sw_input_port.sv
// tb_key_sw_input_port: directed and random stimulus against a hold-window reference model.
module tb_key_sw_input_port;
  localparam int D = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key = 4'hF;
  logic [17:0] sw = '0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        irq;
  int n_checks = 0, n_fail = 0;
  // model: kh[j] = KEY sampled j+1 edges ago, swh likewise for SW
  logic [3:0]  kh [0:D];
  logic [17:0] swh [0:1];
  logic [3:0]  m_stable, m_pend, m_mask;
  logic [31:0] m_rd;
  logic        m_irq;

  key_sw_input_port #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLOCK_50(clk), .reset(rst), .KEY(key), .SW(sw), .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= D; j++) kh[j] = 4'hF;
    swh[0] = '0;
    swh[1] = '0;
    m_stable = 4'hF;
    m_pend = '0;
    m_mask = '0;
    m_rd = '0;
    m_irq = 1'b0;
  endtask

  // a key level is accepted once the synchronised pin has shown the new level for D straight edges
  task automatic model_step();
    logic [3:0] upd, press;
    logic [31:0] rv;
    rv = addr == 2'd0 ? {14'b0, swh[1]} : addr == 2'd1 ? {28'b0, ~m_stable} :
         addr == 2'd2 ? {28'b0, m_pend} : {28'b0, m_mask};
    upd = '0;
    for (int b = 0; b < 4; b++) begin
      upd[b] = 1'b1;
      for (int j = 1; j <= D; j++) if (kh[j][b] == m_stable[b]) upd[b] = 1'b0;
    end
    press = upd & m_stable;
    m_stable = m_stable ^ upd;
    if (rd_en) begin
      m_rd = rv;
      if (addr == 2'd2) m_pend = '0;
    end
    m_pend = m_pend | press;
    if (wr_en && addr == 2'd3) m_mask = wr_data[3:0];
    m_irq = |(m_pend & m_mask);
    for (int j = D; j > 0; j--) kh[j] = kh[j-1];
    kh[0] = key;
    swh[1] = swh[0];
    swh[0] = sw;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check("rd_data", rd_data, m_rd);
    check("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check(tag, rd_data, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wr_data = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_rd", rd_data, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rd(2'd1, 32'h0, "reset_keylvl");
    rd(2'd2, 32'h0, "reset_pend");
    sw = 18'h2A5A5;
    repeat (3) tick();
    rd(2'd0, 32'h0002A5A5, "switches");
    key = 4'hE; repeat (3) tick();
    key = 4'hF; repeat (2) tick();
    key = 4'hE; repeat (2) tick();
    key = 4'hF; repeat (8) tick();
    rd(2'd1, 32'h0, "bounce_keylvl");
    rd(2'd2, 32'h0, "bounce_pend");
    key = 4'hB;
    repeat (5) tick();
    rd(2'd1, 32'h0, "key2_before");
    rd(2'd1, 32'h4, "key2_keylvl");
    rd(2'd2, 32'h4, "key2_pend");
    rd(2'd2, 32'h0, "key2_cleared");
    repeat (2) tick();
    key = 4'hF; repeat (8) tick();
    rd(2'd2, 32'h0, "release_no_pend");
    wr(2'd3, 32'h2);
    key = 4'hD;
    repeat (5) tick();
    check("irq_before", {31'b0, irq}, 32'h0);
    tick();
    check("irq_set", {31'b0, irq}, 32'h1);
    rd(2'd2, 32'h2, "key1_pend");
    check("irq_drop", {31'b0, irq}, 32'h0);
    key = 4'hF; repeat (8) tick();
    key = 4'hE; repeat (8) tick();
    key = 4'h7;
    repeat (5) tick();
    rd(2'd2, 32'h1, "race_rd");
    rd(2'd2, 32'h8, "race_set_wins");
    key = 4'hF; repeat (8) tick();
    addr = 2'd3; wr_data = 32'h5; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rdwr_old_mask", rd_data, 32'h2);
    rd(2'd3, 32'h5, "new_mask");
    key = 4'hE; repeat (2) tick();
    rst = 1'b1;
    model_reset();
    repeat (2) tick();
    check("midrst_rd", rd_data, 32'h0);
    rst = 1'b0;
    repeat (5) tick();
    rd(2'd2, 32'h0, "held_before");
    rd(2'd2, 32'h1, "held_press");
    key = 4'hF;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) key[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) sw = 18'($urandom);
      rd_en = ($urandom_range(0, 2) == 0);
      wr_en = ($urandom_range(0, 7) == 0);
      addr = 2'($urandom);
      wr_data = $urandom;
      tick();
    end
    rd_en = 1'b0; wr_en = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
